// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge path.
package pic_pkg;

    // Acknowledge sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StP1,
        StGap,
        StP2,
        StHold,
        StRecover
    } pic_state_e;

    localparam int unsigned PicVecW = 8;

    // 8086-mode vector layout: T7..T3 from ICW2, low three bits carry the IR level
    localparam logic [7:0] VecT7T3Mask  = 8'hF8;
    localparam logic [7:0] VecLevelMask = 8'h07;

endpackage

// File: rtl/pic_sync2.sv
// Generic two-flop synchroniser with synchronous active-low reset.
module pic_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage capture of an asynchronous input
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-side 8086-mode interrupt acknowledge sequencer: issues two INTA pulses,
// captures the vector during the second and offers it over valid/ready.
// Optional build macro PIC_INTA_SPURIOUS_EN adds the 'spurious' output.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 2,
    parameter int unsigned VEC_W           = PicVecW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             INT_Flag,
    input  logic             int_enable,
    input  logic [VEC_W-1:0] data_Bus,
    output logic             INTA,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    input  logic             vector_ready,
    output logic             busy
`ifdef PIC_INTA_SPURIOUS_EN
    ,
    output logic             spurious
`endif
);

    localparam int unsigned MaxCyc = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                                     INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam logic [CntW-1:0] LowLoad = CntW'(INTA_LOW_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad = CntW'(INTA_GAP_CYCLES - 1);

    pic_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             inta_q, inta_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic             valid_q, valid_d;
    logic             int_s;
    logic             cnt_done;
    logic             capture;
    logic             handshake;

    pic_sync2 #(
        .Width (1)
    ) u_int_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (INT_Flag),
        .q_o    (int_s)
    );

    assign cnt_done  = (cnt_q == '0);
    assign capture   = (state_q == StP2) && cnt_done;
    assign handshake = valid_q && vector_ready;

    // State register plus counter, INTA flop and vector capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            inta_q   <= 1'b1;
            vector_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_q   <= inta_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state: once P1 is entered the PIC is committed, so only timing matters
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (int_s && int_enable) state_d = StP1;
            StP1:      if (cnt_done)            state_d = StGap;
            StGap:     if (cnt_done)            state_d = StP2;
            StP2:      if (cnt_done)            state_d = StHold;
            StHold:    if (handshake)           state_d = StRecover;
            StRecover: if (cnt_done)            state_d = StIdle;
            default:                            state_d = StIdle;
        endcase
    end

    // Outputs and datapath: INTA registered from next state so it never glitches
    always_comb begin
        inta_d   = !((state_d == StP1) || (state_d == StP2));
        cnt_d    = cnt_q;
        vector_d = vector_q;
        valid_d  = valid_q;
        if (state_d != state_q) begin
            case (state_d)
                StP1, StP2:       cnt_d = LowLoad;
                StGap, StRecover: cnt_d = GapLoad;
                default:          cnt_d = '0;
            endcase
        end else if (!cnt_done) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (capture) begin
            vector_d = data_Bus;
            valid_d  = 1'b1;
        end else if (handshake) begin
            valid_d  = 1'b0;
        end
    end

`ifdef PIC_INTA_SPURIOUS_EN
    logic flag_q, flag_d;
    logic spur_q, spur_d;

    // Sticky record of INT dropping before the PIC drives its vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            spur_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
            spur_q <= spur_d;
        end
    end

    // Flag clears on P1 entry; spurious follows the vector's lifetime
    always_comb begin
        flag_d = flag_q;
        spur_d = spur_q;
        if ((state_q == StIdle) && (state_d == StP1)) begin
            flag_d = 1'b0;
        end else if (((state_q == StP1) || (state_q == StGap)) && !int_s) begin
            flag_d = 1'b1;
        end
        if (capture) begin
            spur_d = flag_q;
        end else if (handshake) begin
            spur_d = 1'b0;
        end
    end

    assign spurious = spur_q;
`endif

    assign INTA         = inta_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed self-checking bench for pic_inta_sequencer (default parameters).
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       INT_Flag;
    logic       int_enable;
    logic [7:0] data_Bus;
    logic       INTA;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;
    logic       busy;
`ifdef PIC_INTA_SPURIOUS_EN
    logic       spurious;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pic_inta_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .INT_Flag     (INT_Flag),
        .int_enable   (int_enable),
        .data_Bus     (data_Bus),
        .INTA         (INTA),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .busy         (busy)
`ifdef PIC_INTA_SPURIOUS_EN
        ,
        .spurious     (spurious)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Finish an in-flight sequence: accept the vector and wait for IDLE
    task automatic drain();
        int n;
        n = 0;
        INT_Flag     = 1'b0;
        vector_ready = 1'b1;
        while (busy !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            $display("FAIL drain_timeout: busy=%b required 0", busy);
            tests_failed++;
        end
        vector_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; INT_Flag = 1'b0; int_enable = 1'b1;
        data_Bus = 8'h00; vector_ready = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if ({INTA, busy, vector_valid} !== 3'b100) begin
            $display("FAIL reset_ctrl: INTA/busy/valid=%b required 100",
                     {INTA, busy, vector_valid});
            tests_failed++;
        end
        tests_run++;
        if (vector !== 8'h00) begin
            $display("FAIL reset_vector: got %h required 00", vector);
            tests_failed++;
        end
`ifdef PIC_INTA_SPURIOUS_EN
        tests_run++;
        if (spurious !== 1'b0) begin
            $display("FAIL reset_spurious: got %b required 0", spurious);
            tests_failed++;
        end
`endif
        rst_n = 1'b1;
        tick(); tick();
    endtask

    // Default acknowledge; INT and int_enable drop mid-sequence yet it completes
    task automatic test_basic();
        logic exp_inta;
        int_enable = 1'b1; data_Bus = 8'h0F; INT_Flag = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            tick();
            exp_inta = !(j == 2 || j == 3 || j == 6 || j == 7);
            tests_run++;
            if (INTA !== exp_inta || vector_valid !== (j == 8)) begin
                $display("FAIL basic_cycle%0d: INTA=%b valid=%b required INTA=%b valid=%b",
                         j, INTA, vector_valid, exp_inta, (j == 8));
                tests_failed++;
            end
            if (j == 3) begin
                int_enable = 1'b0;
                INT_Flag   = 1'b0;
            end
        end
        tests_run++;
        if (vector !== 8'h0F) begin
            $display("FAIL basic_vector: got %h required 0F", vector);
            tests_failed++;
        end
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        tests_run++;
        if ({vector_valid, busy} !== 2'b01) begin
            $display("FAIL basic_handshake: valid/busy=%b required 01", {vector_valid, busy});
            tests_failed++;
        end
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_recover1: busy=%b required 1", busy);
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({busy, INTA} !== 2'b01) begin
            $display("FAIL basic_idle: busy/INTA=%b required 01", {busy, INTA});
            tests_failed++;
        end
        int_enable = 1'b1;
        tick();
    endtask

    task automatic test_disabled();
        int bad;
        bad = 0;
        int_enable = 1'b0; INT_Flag = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if ({INTA, busy} !== 2'b10) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            $display("FAIL disabled_hold: %0d bad cycles, required 0", bad);
            tests_failed++;
        end
        int_enable = 1'b1; data_Bus = 8'h77;
        tick();
        tests_run++;
        if ({INTA, busy} !== 2'b01) begin
            $display("FAIL disabled_start: INTA/busy=%b required 01", {INTA, busy});
            tests_failed++;
        end
        for (int j = 0; j < 6; j++) tick();
        tests_run++;
        if (vector_valid !== 1'b1 || vector !== 8'h77) begin
            $display("FAIL disabled_capture: valid=%b vector=%h required 1/77",
                     vector_valid, vector);
            tests_failed++;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        INT_Flag = 1'b1; data_Bus = 8'h12; vector_ready = 1'b0;
        for (int j = 0; j <= 8; j++) tick();
        tests_run++;
        if (vector_valid !== 1'b1 || vector !== 8'h12) begin
            $display("FAIL bp_capture: valid=%b vector=%h required 1/12", vector_valid, vector);
            tests_failed++;
        end
        data_Bus = 8'hAA;
        for (int j = 0; j < 10; j++) begin
            tick();
            if ({INTA, busy, vector_valid} !== 3'b111 || vector !== 8'h12) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d bad cycles, required 0", bad);
            tests_failed++;
        end
        vector_ready = 1'b1; INT_Flag = 1'b0;
        tick();
        vector_ready = 1'b0;
        tests_run++;
        if ({vector_valid, busy} !== 2'b01) begin
            $display("FAIL bp_handshake: valid/busy=%b required 01", {vector_valid, busy});
            tests_failed++;
        end
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            $display("FAIL bp_recover: busy=%b required 1", busy);
            tests_failed++;
        end
        tick();
        tick();
        tests_run++;
        if ({busy, INTA} !== 2'b01) begin
            $display("FAIL bp_idle: busy/INTA=%b required 01", {busy, INTA});
            tests_failed++;
        end
    endtask

    // INT held high and ready held high throughout: two sequences back to back
    task automatic test_back_to_back();
        INT_Flag = 1'b1; vector_ready = 1'b1; data_Bus = 8'h5A;
        for (int j = 0; j <= 8; j++) tick();
        tests_run++;
        if (vector_valid !== 1'b1 || vector !== 8'h5A) begin
            $display("FAIL b2b_first: valid=%b vector=%h required 1/5A", vector_valid, vector);
            tests_failed++;
        end
        data_Bus = 8'h23;
        tick();
        tests_run++;
        if ({vector_valid, busy} !== 2'b01) begin
            $display("FAIL b2b_handshake: valid/busy=%b required 01", {vector_valid, busy});
            tests_failed++;
        end
        tick();
        tick();
        tests_run++;
        if ({busy, INTA} !== 2'b01) begin
            $display("FAIL b2b_idle: busy/INTA=%b required 01", {busy, INTA});
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({busy, INTA} !== 2'b10) begin
            $display("FAIL b2b_restart: busy/INTA=%b required 10", {busy, INTA});
            tests_failed++;
        end
        for (int j = 0; j < 6; j++) tick();
        tests_run++;
        if (vector_valid !== 1'b1 || vector !== 8'h23) begin
            $display("FAIL b2b_second: valid=%b vector=%h required 1/23", vector_valid, vector);
            tests_failed++;
        end
        drain();
    endtask

    task automatic test_reset_mid_p1();
        int bad;
        bad = 0;
        INT_Flag = 1'b1; data_Bus = 8'h99;
        tick(); tick(); tick();
        tests_run++;
        if (INTA !== 1'b0) begin
            $display("FAIL rst_p1_entry: INTA=%b required 0", INTA);
            tests_failed++;
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({INTA, busy, vector_valid} !== 3'b100 || vector !== 8'h00) begin
            $display("FAIL rst_mid_p1: INTA/busy/valid=%b vector=%h required 100/00",
                     {INTA, busy, vector_valid}, vector);
            tests_failed++;
        end
        rst_n = 1'b1; INT_Flag = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if ({INTA, busy, vector_valid} !== 3'b100) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            $display("FAIL rst_no_capture: %0d bad cycles, required 0", bad);
            tests_failed++;
        end
    endtask

`ifdef PIC_INTA_SPURIOUS_EN
    task automatic test_spurious();
        INT_Flag = 1'b1; data_Bus = 8'h44; vector_ready = 1'b0;
        tick(); tick(); tick();
        INT_Flag = 1'b0;
        for (int j = 3; j <= 8; j++) tick();
        tests_run++;
        if (vector_valid !== 1'b1 || vector !== 8'h44 || spurious !== 1'b1) begin
            $display("FAIL spur_set: valid=%b vector=%h spurious=%b required 1/44/1",
                     vector_valid, vector, spurious);
            tests_failed++;
        end
        vector_ready = 1'b1;
        tick();
        tests_run++;
        if ({vector_valid, spurious} !== 2'b00) begin
            $display("FAIL spur_clear: valid/spurious=%b required 00", {vector_valid, spurious});
            tests_failed++;
        end
        drain();
        INT_Flag = 1'b1; data_Bus = 8'h55;
        for (int j = 0; j <= 8; j++) tick();
        tests_run++;
        if (vector_valid !== 1'b1 || vector !== 8'h55 || spurious !== 1'b0) begin
            $display("FAIL spur_normal: valid=%b vector=%h spurious=%b required 1/55/0",
                     vector_valid, vector, spurious);
            tests_failed++;
        end
        drain();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_disabled();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_p1();
`ifdef PIC_INTA_SPURIOUS_EN
        test_spurious();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- CPU-side interrupt acknowledge engine sitting directly downstream of the master PIC.
- Watches the master's INT_Flag and, when interrupts are enabled, generates the two active-low INTA pulses of an 8086-mode acknowledge cycle.
- Captures the vector the PIC drives on data_Bus during the second pulse and hands it to the CPU model over a valid/ready handshake.

Parameters:
- INTA_LOW_CYCLES, 2, clk cycles each INTA pulse is held low (>=1)
- INTA_GAP_CYCLES, 2, clk cycles INTA is high between pulse 1 and pulse 2, and length of post-handoff recovery (>=1)
- VEC_W, 8, width of data_Bus and captured vector

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- INT_Flag  in  1  interrupt request from master PIC, asynchronous, active high
- int_enable  in  1  CPU interrupt-enable flag (IF)
- data_Bus  in  VEC_W  shared PIC data bus, sampled only, never driven
- INTA  out  1  interrupt acknowledge to all PICs, active low
- vector  out  VEC_W  captured interrupt vector
- vector_valid  out  1  vector holds an unconsumed value
- vector_ready  in  1  CPU accepts vector when high together with vector_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-low. When rst_n is low at a rising edge: INTA=1, vector=0, vector_valid=0, busy=0, state=IDLE, synchroniser flops cleared to 0. Reset mid-sequence aborts immediately; INTA returns high on that same edge.
- Synchroniser: INT_Flag passes through two flops to give int_s. All FSM decisions use int_s.
- States and transitions:
  - IDLE: go to P1 when int_s && int_enable. INTA goes low on the same edge that enters P1.
  - P1: INTA=0 for INTA_LOW_CYCLES cycles, then GAP.
  - GAP: INTA=1 for INTA_GAP_CYCLES cycles, then P2.
  - P2: INTA=0 for INTA_LOW_CYCLES cycles. data_Bus is registered into vector on the edge that leaves P2 (last low cycle), and vector_valid is set on that same edge. INTA=1 from that edge. Next state is HOLD.
  - HOLD: INTA=1. On vector_valid && vector_ready, clear vector_valid and go to RECOVER. vector stays stable while valid.
  - RECOVER: INTA=1 for INTA_GAP_CYCLES cycles (flushes the synchroniser as the PIC drops INT), then IDLE.
- Latency: INT_Flag rising before edge k gives INTA low from edge k+2, assuming int_enable=1.
- vector_valid first rises at edge k+2+2*INTA_LOW_CYCLES+INTA_GAP_CYCLES.
- A single shared down-counter, sized $clog2(max(INTA_LOW_CYCLES,INTA_GAP_CYCLES)+1) bits, times P1, GAP, P2 and RECOVER. It reloads on every state entry.
- Boundary conditions:
  - int_enable dropping after IDLE has no effect; the sequence always completes because the PIC is already committed.
  - int_s dropping mid-sequence: the sequence still completes.
  - int_s high during HOLD or RECOVER is ignored.
  - vector_ready high while vector_valid=0 is ignored.
  - vector_ready held high at the edge vector_valid rises: the handshake completes on the following edge, so valid is high for at least one cycle.
  - INTA never glitches; it is driven directly from a flop.

Optional Feature:
- Macro: PIC_INTA_SPURIOUS_EN.
- With the macro defined:
  - Extra output spurious (1 bit, reset 0).
  - A sticky flag sets if int_s is sampled low during any cycle of P1 or GAP.
  - When vector is captured, spurious takes the flag value; vector is still captured unchanged.
  - spurious clears with the vector_valid handshake. The flag clears on entering P1.
- Without the macro: no spurious port and no flag logic. Behaviour is otherwise identical.

Decomposition:
- Shared package pic_pkg holds:
  - state enum (IDLE, P1, GAP, P2, HOLD, RECOVER)
  - default VEC_W
  - 8086 vector-format helper constants (T7..T3 mask 8'hF8, level mask 8'h07)
- One natural sub-module: pic_sync2, a generic two-flop synchroniser with synchronous active-low reset, used for INT_Flag.
- FSM, counter and capture register stay in the top.

Test Plan:
- Reset mid-P1: assert rst_n=0 while INTA=0 -> INTA=1, busy=0, vector_valid=0 on the next edge. No capture occurs.
- Basic acknowledge, defaults: int_enable=1, INT_Flag rises, PIC drives 8'h0F during P2 ->
  - INTA low for cycles 2-3 and 6-7 after the INT edge
  - vector=8'h0F, vector_valid=1 at cycle 8
- Interrupts disabled: INT_Flag=1, int_enable=0 for 20 cycles -> INTA stays 1, busy=0. Raising int_enable then starts P1 on the next edge.
- Backpressure: vector_ready=0 for 10 cycles after capture of 8'h12 ->
  - vector_valid held, vector stable at 8'h12, INTA=1, no new sequence despite INT_Flag=1
  - ready=1 completes the handshake; RECOVER lasts 2 cycles
- Back-to-back: INT_Flag held high through RECOVER with a second vector 8'h23 -> a new P1 starts immediately after RECOVER, and the second capture is 8'h23.
- With PIC_INTA_SPURIOUS_EN: INT_Flag pulses high 3 cycles then drops before GAP ends -> sequence completes, vector captured, spurious=1. A normal acknowledge afterwards gives spurious=0.
